mouse_position_tracker: RTL and testbench
=========================================

Name: mouse_position_tracker

Overview:
- Parametrised successor to the fixed 160x120 mouse position logic.
- Accepts decoded PS/2 packets (status byte, dX, dY, dZ) over a valid/ready handshake.
- Accumulates bounded X/Y/Z positions with selectable clamp or wrap mode, button edge events and sticky overflow flags.
- Sits between the PS/2 packet decoder and the VGA/seven-segment consumers.

Parameters:
- X_WIDTH, 8, width of MOUSE_X.
- Y_WIDTH, 8, width of MOUSE_Y.
- Z_WIDTH, 8, width of signed MOUSE_Z.
- X_MAX, 159, largest legal X.
- Y_MAX, 119, largest legal Y.
- X_INIT, 80, X after reset.
- Y_INIT, 60, Y after reset.
- WRAP_MODE, 0, 0 = clamp at edges, 1 = wrap modulo (MAX+1).
- INVERT_Y, 1, 1 = screen Y grows downward (Y -= dY).
- ACCEL_THRESH, 8, magnitude above which a delta is doubled; used only with MOUSE_ACCEL_EN.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous reset, active-low.
- PKT_VALID  in  1  packet present.
- PKT_READY  out  1  tracker can accept a packet.
- PKT_STATUS  in  8  PS/2 byte0: [0]L [1]R [2]M [3]always1 [4]Xsign [5]Ysign [6]Xovf [7]Yovf.
- PKT_DX  in  8  X delta low byte.
- PKT_DY  in  8  Y delta low byte.
- PKT_DZ  in  8  signed wheel delta.
- CLR_OVF  in  1  clear sticky overflow flags.
- MOUSE_X  out  X_WIDTH  X position.
- MOUSE_Y  out  Y_WIDTH  Y position.
- MOUSE_Z  out  Z_WIDTH  signed wheel accumulator.
- MOUSE_STATUS  out  4  registered PKT_STATUS[3:0].
- BTN_PRESS  out  3  one-cycle rising-edge pulses for L/R/M.
- BTN_RELEASE  out  3  one-cycle falling-edge pulses for L/R/M.
- OVF_X, OVF_Y, OVF_Z  out  1 each  sticky overflow flags.
- UPDATE  out  1  one-cycle pulse when the outputs change.

Behaviour:
- Reset (RESET=0 at a CLK edge, in any state):
  - FSM returns to IDLE; any in-flight packet is discarded.
  - MOUSE_X=X_INIT, MOUSE_Y=Y_INIT, MOUSE_Z=0, MOUSE_STATUS=4'b1000.
  - BTN_PRESS, BTN_RELEASE, all OVF flags and UPDATE are 0; PKT_READY=1 from the first cycle after reset.
- FSM states:
  - IDLE (PKT_READY=1): on PKT_VALID&PKT_READY, capture all inputs and go to ACCUM.
  - ACCUM: form signed sums and go to NORM.
  - NORM: apply at most one range correction per axis per cycle; stay while any axis is out of range, else go to COMMIT.
  - COMMIT: register the outputs, pulse UPDATE, return to IDLE.
- Latency: UPDATE is asserted 3+n cycles after the accept edge, where n = number of extra NORM cycles; clamp mode always gives n=0.
- Throughput: at most one packet per 4 cycles. PKT_READY is 0 outside IDLE.
- Deltas:
  - dX = signed {PKT_STATUS[4], PKT_DX}; dY = signed {PKT_STATUS[5], PKT_DY}; dZ = signed PKT_DZ.
  - If Xovf (or Yovf) is set, that axis delta is treated as 0 and OVF_X (or OVF_Y) is set.
- Sums: computed in max(X_WIDTH,9)+2 signed bits (same rule for Y).
  - Clamp mode: a result below 0 becomes 0; a result above MAX becomes MAX. Clamping is not an overflow.
  - Wrap mode: each NORM cycle adds (MAX+1) if the value is negative, or subtracts (MAX+1) if the value is above MAX.
- Z: saturating add within the Z_WIDTH signed range. Saturation sets OVF_Z.
- Buttons: at COMMIT, BTN_PRESS = new & ~old and BTN_RELEASE = ~new & old over bits [2:0]. Pulses coincide with UPDATE.
- CLR_OVF: clears the flags in any state. If a flag-setting event occurs in the same cycle, set wins.

Optional Feature:
- Macro: MOUSE_ACCEL_EN.
- Defined: in ACCUM, any axis delta (X/Y) with |d| > ACCEL_THRESH is doubled (one extra sum bit) before summation.
- Undefined: deltas are used unscaled and ACCEL_THRESH is ignored.

Decomposition:
- Package mouse_tracker_pkg holds:
  - FSM state enum (IDLE, ACCUM, NORM, COMMIT).
  - PS/2 status bit-index constants.
  - The signed-sum width function.
- Sub-module mouse_axis_norm, instantiated for X and Y: holds the signed accumulator, performs the clamp or single-step wrap correction, and exposes an in_range flag.

Test Plan:
- Reset with defaults -> X=80, Y=60, Z=0, STATUS=1000, PKT_READY=1, all flags 0.
- STATUS=08, DX=30, DY=45 -> X=110, Y=15, UPDATE pulses exactly 3 cycles after accept.
- Clamp: X=110, DX=+127 -> X=159, OVF_X=0; then STATUS=18, DX=0x00 (-256) -> X=0.
- WRAP_MODE=1: X=150, DX=+255 -> 405 -> 245 -> 85; UPDATE 5 cycles after accept (n=2).
- Z=120, DZ=+50 -> Z=127, OVF_Z=1; CLR_OVF asserted in the same cycle as a new saturation -> OVF_Z stays 1.
- STATUS=48, DX=0x10 -> X unchanged, OVF_X=1. Then STATUS=09 after 08 -> BTN_PRESS=001 for one cycle. RESET low during NORM -> IDLE, init values, no UPDATE.

Source files
------------

// File: rtl/mouse_tracker_pkg.sv
// -----------------------------------------------------------------------------
// mouse_tracker_pkg
// Shared definitions for the mouse position tracker:
//   - state_t       : packet-processing FSM states
//   - STAT_*        : bit positions inside the PS/2 status byte (byte0)
//   - sum_width()   : width of the signed per-axis accumulator
//   - scale_delta() : optional delta doubling used when acceleration is built in
// -----------------------------------------------------------------------------
package mouse_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    NORM   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int STAT_L     = 0;
  localparam int STAT_R     = 1;
  localparam int STAT_M     = 2;
  localparam int STAT_ONE   = 3;
  localparam int STAT_XSIGN = 4;
  localparam int STAT_YSIGN = 5;
  localparam int STAT_XOVF  = 6;
  localparam int STAT_YOVF  = 7;

  // Position plus a 9-bit PS/2 delta (possibly doubled) needs max(w,9)+2 bits.
  function automatic int sum_width(input int w);
    return ((w > 9) ? w : 9) + 2;
  endfunction

  function automatic int scale_delta(input int d, input int thresh, input bit en);
    if (en && (d > thresh || d < -thresh)) return d * 2;
    return d;
  endfunction

endpackage

// File: rtl/mouse_axis_norm.sv
// -----------------------------------------------------------------------------
// mouse_axis_norm
// One axis of the tracker. Loads the raw signed sum, clamps it immediately in
// clamp mode, or walks it back into [0, MAX] one (MAX+1) step per cycle in
// wrap mode.
// Ports:
//   i_clk       clock
//   i_load      load i_sum (clamped when WRAP_MODE == 0)
//   i_step      apply one wrap correction if out of range
//   i_sum       signed sum, SW bits
//   o_pos       low W bits of the accumulator (valid once in range)
//   o_in_range  accumulator currently lies in [0, MAX]
// -----------------------------------------------------------------------------
module mouse_axis_norm #(
  parameter int W         = 8,
  parameter int MAX       = 159,
  parameter int SW        = 11,
  parameter int WRAP_MODE = 0
) (
  input  logic                 i_clk,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic signed [SW-1:0] i_sum,
  output logic        [W-1:0]  o_pos,
  output logic                 o_in_range
);

  localparam logic signed [SW-1:0] L_MAX  = SW'(MAX);
  localparam logic signed [SW-1:0] L_SPAN = SW'(MAX + 1);

  logic signed [SW-1:0] r_acc;
  logic signed [SW-1:0] w_clamped;

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_clamped = i_sum;
    if (i_sum < 0) w_clamped = '0;
    else if (i_sum > L_MAX) w_clamped = L_MAX;
  end

  assign o_in_range = (r_acc >= 0) && (r_acc <= L_MAX);
  assign o_pos      = r_acc[W-1:0];

  // Clamping at load time keeps clamp mode to a single NORM cycle.
  // NOTE: the accumulator is pure datapath, only read after a load, so it
  // carries no reset.
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs from before the edge.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_acc <= (WRAP_MODE != 0) ? i_sum : w_clamped;
    end else if (i_step && !o_in_range) begin
      r_acc <= (r_acc < 0) ? r_acc + L_SPAN : r_acc - L_SPAN;
    end
  end

endmodule

// File: rtl/mouse_position_tracker.sv
// -----------------------------------------------------------------------------
// mouse_position_tracker
// Accepts decoded PS/2 packets over valid/ready and maintains bounded X/Y,
// a saturating signed wheel count, button edge pulses and sticky overflow
// flags. FSM: IDLE -> ACCUM -> NORM (1+n cycles) -> COMMIT -> IDLE.
// Build option: define MOUSE_ACCEL_EN to double X/Y deltas whose magnitude
// exceeds ACCEL_THRESH.
// Ports:
//   CLK, RESET (sync, active-low)
//   PKT_VALID/PKT_READY handshake; PKT_STATUS/DX/DY/DZ packet fields
//   CLR_OVF      clear sticky OVF_X/Y/Z (a same-cycle set wins)
//   MOUSE_X/Y/Z  positions, MOUSE_STATUS registered status[3:0]
//   BTN_PRESS/BTN_RELEASE one-cycle L/R/M edge pulses, UPDATE commit pulse
// -----------------------------------------------------------------------------
module mouse_position_tracker
  import mouse_tracker_pkg::*;
#(
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 8,
  parameter int Z_WIDTH      = 8,
  parameter int X_MAX        = 159,
  parameter int Y_MAX        = 119,
  parameter int X_INIT       = 80,
  parameter int Y_INIT       = 60,
  parameter int WRAP_MODE    = 0,
  parameter int INVERT_Y     = 1,
  parameter int ACCEL_THRESH = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      PKT_VALID,
  output logic                      PKT_READY,
  input  logic [7:0]                PKT_STATUS,
  input  logic [7:0]                PKT_DX,
  input  logic [7:0]                PKT_DY,
  input  logic [7:0]                PKT_DZ,
  input  logic                      CLR_OVF,
  output logic [X_WIDTH-1:0]        MOUSE_X,
  output logic [Y_WIDTH-1:0]        MOUSE_Y,
  output logic signed [Z_WIDTH-1:0] MOUSE_Z,
  output logic [3:0]                MOUSE_STATUS,
  output logic [2:0]                BTN_PRESS,
  output logic [2:0]                BTN_RELEASE,
  output logic                      OVF_X,
  output logic                      OVF_Y,
  output logic                      OVF_Z,
  output logic                      UPDATE
);

`ifdef MOUSE_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  localparam int SW_X  = sum_width(X_WIDTH);
  localparam int SW_Y  = sum_width(Y_WIDTH);
  localparam int Z_MAX = (1 << (Z_WIDTH - 1)) - 1;
  localparam int Z_MIN = -(1 << (Z_WIDTH - 1));

  state_t r_state, w_next;
  logic   w_load, w_step, w_commit, w_accept;

  logic [7:0] r_cap_status, r_cap_dx, r_cap_dy, r_cap_dz;

  logic [X_WIDTH-1:0]        r_x;
  logic [Y_WIDTH-1:0]        r_y;
  logic signed [Z_WIDTH-1:0] r_z;
  logic [3:0]                r_status;
  logic [2:0]                r_press, r_release;
  logic                      r_ovf_x, r_ovf_y, r_ovf_z, r_update;

  int                        w_dx, w_dy, w_z_sum;
  logic signed [SW_X-1:0]    w_sum_x;
  logic signed [SW_Y-1:0]    w_sum_y;
  logic [X_WIDTH-1:0]        w_pos_x;
  logic [Y_WIDTH-1:0]        w_pos_y;
  logic                      w_x_in_range, w_y_in_range;
  logic signed [Z_WIDTH-1:0] w_z_next;
  logic                      w_z_sat;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    PKT_READY = 1'b0;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_commit  = 1'b0;
    unique case (r_state)
      IDLE: begin
        PKT_READY = 1'b1;
        if (PKT_VALID) w_next = ACCUM;
      end
      ACCUM: begin
        w_load = 1'b1;
        w_next = NORM;
      end
      NORM: begin
        w_step = 1'b1;
        if (w_x_in_range && w_y_in_range) w_next = COMMIT;
      end
      COMMIT: begin
        w_commit = 1'b1;
        w_next   = IDLE;
      end
    endcase
  end

  assign w_accept = PKT_READY & PKT_VALID;

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_cap_status <= PKT_STATUS;
      r_cap_dx     <= PKT_DX;
      r_cap_dy     <= PKT_DY;
      r_cap_dz     <= PKT_DZ;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    w_dx = 0;
    w_dy = 0;
    if (!r_cap_status[STAT_XOVF])
      w_dx = int'($signed({r_cap_status[STAT_XSIGN], r_cap_dx}));
    if (!r_cap_status[STAT_YOVF])
      w_dy = int'($signed({r_cap_status[STAT_YSIGN], r_cap_dy}));
    if (INVERT_Y != 0) w_dy = -w_dy;
    w_dx    = scale_delta(w_dx, ACCEL_THRESH, ACCEL_ON);
    w_dy    = scale_delta(w_dy, ACCEL_THRESH, ACCEL_ON);
    w_sum_x = SW_X'(int'(r_x) + w_dx);
    w_sum_y = SW_Y'(int'(r_y) + w_dy);

    w_z_sum  = int'(r_z) + int'($signed(r_cap_dz));
    w_z_next = Z_WIDTH'(w_z_sum);
    w_z_sat  = 1'b0;
    if (w_z_sum > Z_MAX) begin
      w_z_next = Z_WIDTH'(Z_MAX);
      w_z_sat  = 1'b1;
    end else if (w_z_sum < Z_MIN) begin
      w_z_next = Z_WIDTH'(Z_MIN);
      w_z_sat  = 1'b1;
    end
  end

  mouse_axis_norm #(
    .W(X_WIDTH), .MAX(X_MAX), .SW(SW_X), .WRAP_MODE(WRAP_MODE)
  ) u_norm_x (
    .i_clk(CLK), .i_load(w_load), .i_step(w_step), .i_sum(w_sum_x),
    .o_pos(w_pos_x), .o_in_range(w_x_in_range)
  );

  mouse_axis_norm #(
    .W(Y_WIDTH), .MAX(Y_MAX), .SW(SW_Y), .WRAP_MODE(WRAP_MODE)
  ) u_norm_y (
    .i_clk(CLK), .i_load(w_load), .i_step(w_step), .i_sum(w_sum_y),
    .o_pos(w_pos_y), .o_in_range(w_y_in_range)
  );

  // ---------------------------------------------------------------- outputs
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_x       <= X_WIDTH'(X_INIT);
      r_y       <= Y_WIDTH'(Y_INIT);
      r_z       <= '0;
      r_status  <= 4'b1000;
      r_press   <= '0;
      r_release <= '0;
      r_update  <= 1'b0;
      r_ovf_x   <= 1'b0;
      r_ovf_y   <= 1'b0;
      r_ovf_z   <= 1'b0;
    end else begin
      r_update  <= w_commit;
      r_press   <= '0;
      r_release <= '0;
      // Clear first, then OR in the set term so a same-cycle event wins.
      r_ovf_x <= (r_ovf_x & ~CLR_OVF) | (w_commit & r_cap_status[STAT_XOVF]);
      r_ovf_y <= (r_ovf_y & ~CLR_OVF) | (w_commit & r_cap_status[STAT_YOVF]);
      r_ovf_z <= (r_ovf_z & ~CLR_OVF) | (w_commit & w_z_sat);
      if (w_commit) begin
        r_x       <= w_pos_x;
        r_y       <= w_pos_y;
        r_z       <= w_z_next;
        r_status  <= r_cap_status[STAT_ONE:STAT_L];
        r_press   <= r_cap_status[STAT_M:STAT_L] & ~r_status[STAT_M:STAT_L];
        r_release <= ~r_cap_status[STAT_M:STAT_L] & r_status[STAT_M:STAT_L];
      end
    end
  end

  assign MOUSE_X      = r_x;
  assign MOUSE_Y      = r_y;
  assign MOUSE_Z      = r_z;
  assign MOUSE_STATUS = r_status;
  assign BTN_PRESS    = r_press;
  assign BTN_RELEASE  = r_release;
  assign OVF_X        = r_ovf_x;
  assign OVF_Y        = r_ovf_y;
  assign OVF_Z        = r_ovf_z;
  assign UPDATE       = r_update;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// -----------------------------------------------------------------------------
// tb_mouse_position_tracker
// Two trackers: index 0 uses defaults (clamp), index 1 uses WRAP_MODE=1.
// Directed packets push hand-computed expectations into a per-DUT queue; a
// monitor per DUT pops and compares on every UPDATE pulse, including latency.
// -----------------------------------------------------------------------------
module tb_mouse_position_tracker;

  typedef struct packed {
    int         id;
    logic [7:0] x, y, z;
    logic [3:0] st;
    logic [2:0] pr, rl;
    logic       ox, oy, oz;
    int         lat;
    int         acc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       valid [2];
  logic       ready [2];
  logic [7:0] st_i  [2];
  logic [7:0] dx_i  [2];
  logic [7:0] dy_i  [2];
  logic [7:0] dz_i  [2];
  logic       clr   [2];
  logic [7:0] x_o   [2];
  logic [7:0] y_o   [2];
  logic [7:0] z_o   [2];
  logic [3:0] st_o  [2];
  logic [2:0] pr_o  [2];
  logic [2:0] rl_o  [2];
  logic       ox_o  [2];
  logic       oy_o  [2];
  logic       oz_o  [2];
  logic       upd   [2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_upd0 = 0;
  int   n_upd1 = 0;

  mouse_position_tracker dut_c (
    .CLK(clk), .RESET(rst_n), .PKT_VALID(valid[0]), .PKT_READY(ready[0]),
    .PKT_STATUS(st_i[0]), .PKT_DX(dx_i[0]), .PKT_DY(dy_i[0]), .PKT_DZ(dz_i[0]),
    .CLR_OVF(clr[0]), .MOUSE_X(x_o[0]), .MOUSE_Y(y_o[0]), .MOUSE_Z(z_o[0]),
    .MOUSE_STATUS(st_o[0]), .BTN_PRESS(pr_o[0]), .BTN_RELEASE(rl_o[0]),
    .OVF_X(ox_o[0]), .OVF_Y(oy_o[0]), .OVF_Z(oz_o[0]), .UPDATE(upd[0])
  );

  mouse_position_tracker #(.WRAP_MODE(1)) dut_w (
    .CLK(clk), .RESET(rst_n), .PKT_VALID(valid[1]), .PKT_READY(ready[1]),
    .PKT_STATUS(st_i[1]), .PKT_DX(dx_i[1]), .PKT_DY(dy_i[1]), .PKT_DZ(dz_i[1]),
    .CLR_OVF(clr[1]), .MOUSE_X(x_o[1]), .MOUSE_Y(y_o[1]), .MOUSE_Z(z_o[1]),
    .MOUSE_STATUS(st_o[1]), .BTN_PRESS(pr_o[1]), .BTN_RELEASE(rl_o[1]),
    .OVF_X(ox_o[1]), .OVF_Y(oy_o[1]), .OVF_Z(oz_o[1]), .UPDATE(upd[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Compare one UPDATE against the oldest expectation, then confirm the
  // pulses last exactly one cycle.
  task automatic handle(input int d);
    exp_t  e;
    string p;
    if (qsize(d) == 0) begin
      check($sformatf("dut%0d_unexpected_update", d), upd[d], 0);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      p = $sformatf("dut%0d_p%0d", d, e.id);
      check({p, "_x"},       x_o[d],  e.x);
      check({p, "_y"},       y_o[d],  e.y);
      check({p, "_z"},       z_o[d],  e.z);
      check({p, "_status"},  st_o[d], e.st);
      check({p, "_press"},   pr_o[d], e.pr);
      check({p, "_release"}, rl_o[d], e.rl);
      check({p, "_ovf_x"},   ox_o[d], e.ox);
      check({p, "_ovf_y"},   oy_o[d], e.oy);
      check({p, "_ovf_z"},   oz_o[d], e.oz);
      check({p, "_latency"}, cyc - e.acc, e.lat);
      @(negedge clk);
      check({p, "_update_one_cycle"}, upd[d], 0);
      check({p, "_pulses_one_cycle"}, {pr_o[d], rl_o[d]}, 0);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (upd[0] === 1'b1) begin
      n_upd0++;
      handle(0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (upd[1] === 1'b1) begin
      n_upd1++;
      handle(1);
    end
  end

  task automatic send(input int d, input logic [7:0] st, dx, dy, dz, input exp_t e,
                      input bit push);
    int t;
    t = 0;
    @(negedge clk);
    while (ready[d] !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("dut%0d_p%0d_ready_idle", d, e.id), ready[d], 1);
    valid[d] = 1'b1;
    st_i[d]  = st;
    dx_i[d]  = dx;
    dy_i[d]  = dy;
    dz_i[d]  = dz;
    @(posedge clk);
    #1;
    valid[d] = 1'b0;
    e.acc    = cyc;
    if (push) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    check($sformatf("dut%0d_p%0d_ready_busy", d, e.id), ready[d], 0);
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    while (qsize(d) != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("dut%0d_drain", d), qsize(d), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pkt(input int d, input logic [7:0] st, dx, dy, dz,
                     input int id, input logic [7:0] x, y, z, input logic [3:0] s,
                     input logic [2:0] pr, rl, input logic ox, oy, oz, input int lat);
    exp_t e;
    e = '{id: id, x: x, y: y, z: z, st: s, pr: pr, rl: rl,
          ox: ox, oy: oy, oz: oz, lat: lat, acc: 0};
    send(d, st, dx, dy, dz, e, 1'b1);
    drain(d);
  endtask

  task automatic check_state(input int d, input string n, input logic [7:0] x, y, z,
                             input logic [3:0] s, input logic ox, oy, oz);
    check({n, "_x"},      x_o[d],  x);
    check({n, "_y"},      y_o[d],  y);
    check({n, "_z"},      z_o[d],  z);
    check({n, "_status"}, st_o[d], s);
    check({n, "_ready"},  ready[d], 1);
    check({n, "_ovf"},    {ox_o[d], oy_o[d], oz_o[d]}, {ox, oy, oz});
    check({n, "_pulses"}, {pr_o[d], rl_o[d], upd[d]}, 0);
  endtask

  task automatic clr_pulse(input int d);
    @(negedge clk);
    clr[d] = 1'b1;
    @(negedge clk);
    clr[d] = 1'b0;
  endtask

  initial begin
    exp_t e_none;
    int   base;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0; clr[i] = 1'b0;
      st_i[i] = 8'h08; dx_i[i] = '0; dy_i[i] = '0; dz_i[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_state(0, "reset_c", 8'd80, 8'd60, 8'h00, 4'h8, 0, 0, 0);
    check_state(1, "reset_w", 8'd80, 8'd60, 8'h00, 4'h8, 0, 0, 0);

    // ---- wrap-mode tracker
    pkt(1, 8'h08, 8'h46, 8'h00, 8'h00, 1, 8'd150, 8'd60, 8'h00, 4'h8, 0, 0, 0, 0, 0, 3);
    pkt(1, 8'h08, 8'hFF, 8'h00, 8'h00, 2, 8'd85,  8'd60, 8'h00, 4'h8, 0, 0, 0, 0, 0, 5);
    pkt(1, 8'h18, 8'h00, 8'h00, 8'h00, 3, 8'd149, 8'd60, 8'h00, 4'h8, 0, 0, 0, 0, 0, 5);
    pkt(1, 8'h08, 8'h00, 8'h50, 8'h00, 4, 8'd149, 8'd100, 8'h00, 4'h8, 0, 0, 0, 0, 0, 4);

    // ---- clamp-mode tracker: motion and clamping
    pkt(0, 8'h08, 8'h1E, 8'h2D, 8'h00, 1, 8'd110, 8'd15, 8'h00, 4'h8, 0, 0, 0, 0, 0, 3);
    pkt(0, 8'h08, 8'h7F, 8'h00, 8'h00, 2, 8'd159, 8'd15, 8'h00, 4'h8, 0, 0, 0, 0, 0, 3);
    pkt(0, 8'h18, 8'h00, 8'h00, 8'h00, 3, 8'd0,   8'd15, 8'h00, 4'h8, 0, 0, 0, 0, 0, 3);
    pkt(0, 8'h28, 8'h00, 8'hF6, 8'h00, 4, 8'd0,   8'd25, 8'h00, 4'h8, 0, 0, 0, 0, 0, 3);
    pkt(0, 8'h08, 8'h00, 8'h50, 8'h00, 5, 8'd0,   8'd0,  8'h00, 4'h8, 0, 0, 0, 0, 0, 3);

    // ---- wheel saturation and clear/set priority
    pkt(0, 8'h08, 8'h00, 8'h00, 8'h78, 6, 8'd0, 8'd0, 8'h78, 4'h8, 0, 0, 0, 0, 0, 3);
    pkt(0, 8'h08, 8'h00, 8'h00, 8'h32, 7, 8'd0, 8'd0, 8'h7F, 4'h8, 0, 0, 0, 0, 1, 3);
    clr[0] = 1'b1;
    pkt(0, 8'h08, 8'h00, 8'h00, 8'h32, 8, 8'd0, 8'd0, 8'h7F, 4'h8, 0, 0, 0, 0, 1, 3);
    clr[0] = 1'b0;
    clr_pulse(0);
    check("clr_ovf_z", oz_o[0], 0);
    pkt(0, 8'h08, 8'h00, 8'h00, 8'h80, 9,  8'd0, 8'd0, 8'hFF, 4'h8, 0, 0, 0, 0, 0, 3);
    pkt(0, 8'h08, 8'h00, 8'h00, 8'h80, 10, 8'd0, 8'd0, 8'h80, 4'h8, 0, 0, 0, 0, 1, 3);
    clr_pulse(0);

    // ---- X overflow and button edges
    pkt(0, 8'h48, 8'h10, 8'h00, 8'h00, 11, 8'd0, 8'd0, 8'h80, 4'h8, 3'b000, 3'b000, 1, 0, 0, 3);
    pkt(0, 8'h09, 8'h00, 8'h00, 8'h00, 12, 8'd0, 8'd0, 8'h80, 4'h9, 3'b001, 3'b000, 1, 0, 0, 3);
    pkt(0, 8'h0E, 8'h00, 8'h00, 8'h00, 13, 8'd0, 8'd0, 8'h80, 4'hE, 3'b110, 3'b001, 1, 0, 0, 3);
    pkt(0, 8'h08, 8'h00, 8'h00, 8'h00, 14, 8'd0, 8'd0, 8'h80, 4'h8, 3'b000, 3'b110, 1, 0, 0, 3);
    clr_pulse(0);
    check("clr_ovf_x", ox_o[0], 0);

    // ---- Y overflow: delta would have moved Y to 16 if applied
    pkt(0, 8'hA8, 8'h00, 8'hF0, 8'h00, 15, 8'd0, 8'd0, 8'h80, 4'h8, 0, 0, 0, 1, 0, 3);

    // ---- reset while the packet sits in NORM: discarded, no UPDATE
    base   = n_upd0;
    e_none = '{id: 16, x: 0, y: 0, z: 0, st: 0, pr: 0, rl: 0,
               ox: 0, oy: 0, oz: 0, lat: 0, acc: 0};
    send(0, 8'h09, 8'h05, 8'h00, 8'h00, e_none, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_state(0, "reset_in_norm", 8'd80, 8'd60, 8'h00, 4'h8, 0, 0, 0);
    repeat (8) @(negedge clk);
    check("reset_in_norm_no_update", n_upd0 - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
